spi_minion_frame_ctrl: RTL and testbench

SPI minion (mode 0: CPOL=0, CPHA=0) frame controller, MSB first. It synchronises raw cs/sclk/mosi pins into the clk domain and sequences the shift registers, packing bits into words. It exchanges words with the core over val/rdy handshakes: one rx holding register and one tx holding register. It sits between the pad ring and the SPI packet/adapter logic.

---
 rtl/spi_minion_pkg.sv | 18 +
 rtl/spi_pin_sync.sv | 29 ++
 rtl/spi_minion_frame_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_spi_minion_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_minion_pkg.sv
// Shared state encodings and sizing helper for the SPI minion frame controller.
// Pure declarations: no latency, no flow control.
// Imported by the frame controller top.
package spi_minion_pkg;

    localparam logic IDLE   = 1'b0;
    localparam logic ACTIVE = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Three-flop pad synchroniser with level and edge outputs.
// Latency: pin change shows on level/edge after 2 clk; no backpressure.
// Edges compare stage1 against stage2 so each edge pulses for exactly one clk.
module spi_pin_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {3{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[1:0], pin_i};
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = ~sync_q[2] &  sync_q[1];
    assign fall_o  =  sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/spi_minion_frame_ctrl.sv
// SPI mode-0 minion: packs MSB-first bits into words, one rx and one tx holding register.
// Latency: rx_msg/rx_val update 1 clk after the synced sclk rise of the last bit.
// Backpressure: rx_rdy low on word completion drops the new word (overflow); empty tx shifts zeros (underflow).
module spi_minion_frame_ctrl
    import spi_minion_pkg::*;
#(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_en,
    output logic [nbits-1:0] rx_msg,
    output logic             rx_val,
    input  logic             rx_rdy,
    input  logic [nbits-1:0] tx_msg,
    input  logic             tx_val,
    output logic             tx_rdy,
    input  logic             clr_status,
    output logic             overflow,
    output logic             underflow
);

    localparam int CNT_W = clog2(nbits);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(nbits - 1);

    logic cs_lvl, cs_rise, cs_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic sync_unused;

    spi_pin_sync #(.RESET_VALUE(1'b1)) u_cs_sync (
        .clk(clk), .reset(reset), .pin_i(cs),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_pin_sync #(.RESET_VALUE(1'b0)) u_sclk_sync (
        .clk(clk), .reset(reset), .pin_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_pin_sync #(.RESET_VALUE(1'b0)) u_mosi_sync (
        .clk(clk), .reset(reset), .pin_i(mosi),
        .level_o(mosi_lvl), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    assign sync_unused = &{1'b0, cs_lvl, sclk_lvl, mosi_rise, mosi_fall};

    logic             state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [nbits-1:0] tx_shift_q, tx_shift_d;
    logic [nbits-1:0] rx_shift_q, rx_shift_d;
    logic [nbits-1:0] rx_msg_q, rx_msg_d;
    logic             rx_val_q, rx_val_d;
    logic [nbits-1:0] tx_hold_q, tx_hold_d;
    logic             tx_full_q, tx_full_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             do_rise, do_fall, do_load, word_done;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        rx_msg_d    = rx_msg_q;
        rx_val_d    = rx_val_q;
        tx_hold_d   = tx_hold_q;
        tx_full_d   = tx_full_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        do_rise     = 1'b0;
        do_fall     = 1'b0;
        do_load     = 1'b0;
        word_done   = 1'b0;

        // Clears first so a same-cycle set event below wins.
        if (clr_status) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end

        if (rx_val_q && rx_rdy) rx_val_d = 1'b0;

        if (tx_val && !tx_full_q) begin
            tx_hold_d = tx_msg;
            tx_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = ACTIVE;
                    bit_cnt_d = '0;
                    do_load   = 1'b1;
                    do_rise   = sclk_rise;
                end
            end
            default: begin
                if (cs_rise) begin
                    state_d    = IDLE;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                end else begin
                    do_rise = sclk_rise;
                    do_fall = sclk_fall;
                end
            end
        endcase

        if (do_rise) begin
            rx_shift_d = {rx_shift_q[nbits-2:0], mosi_lvl};
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                word_done = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end

        // A fall with bit_cnt==0 is the boundary after a completed word.
        if (do_fall) begin
            if (bit_cnt_q == '0) begin
                do_load = 1'b1;
            end else begin
                tx_shift_d = tx_shift_q << 1;
            end
        end

        if (do_load) begin
            if (tx_full_q) begin
                tx_shift_d = tx_hold_q;
                tx_full_d  = 1'b0;
            end else begin
                tx_shift_d  = '0;
                underflow_d = 1'b1;
            end
        end

        if (word_done) begin
            if (rx_val_q && !rx_rdy) begin
                overflow_d = 1'b1;
            end else begin
                rx_msg_d = {rx_shift_q[nbits-2:0], mosi_lvl};
                rx_val_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tx_shift_q  <= '0;
            rx_shift_q  <= '0;
            rx_msg_q    <= '0;
            rx_val_q    <= 1'b0;
            tx_hold_q   <= '0;
            tx_full_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            rx_msg_q    <= rx_msg_d;
            rx_val_q    <= rx_val_d;
            tx_hold_q   <= tx_hold_d;
            tx_full_q   <= tx_full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign miso      = (state_q == ACTIVE) & tx_shift_q[nbits-1];
    assign miso_en   = (state_q == ACTIVE);
    assign rx_msg    = rx_msg_q;
    assign rx_val    = rx_val_q;
    assign tx_rdy    = ~tx_full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_spi_minion_frame_ctrl.sv
// Directed bench for spi_minion_frame_ctrl (nbits=8, sclk period 8 clk).
// Frames end with cs rising together with the last sclk fall, so no trailing word-boundary load occurs.
module tb_spi_minion_frame_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs, sclk, mosi;
    logic       miso, miso_en;
    logic [7:0] rx_msg;
    logic       rx_val, rx_rdy;
    logic [7:0] tx_msg;
    logic       tx_val, tx_rdy;
    logic       clr_status, overflow, underflow;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] rx_q[$];

    spi_minion_frame_ctrl #(.nbits(8)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .miso_en(miso_en), .rx_msg(rx_msg), .rx_val(rx_val),
        .rx_rdy(rx_rdy), .tx_msg(tx_msg), .tx_val(tx_val), .tx_rdy(tx_rdy),
        .clr_status(clr_status), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_val && rx_rdy) rx_q.push_back(rx_msg);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tx_write(input logic [7:0] w);
        int k;
        k = 0;
        while (!tx_rdy && k < 200) begin
            wait_clk(1);
            k++;
        end
        check("tx_rdy_before_write", tx_rdy, 1);
        tx_msg = w;
        tx_val = 1'b1;
        wait_clk(1);
        tx_val = 1'b0;
    endtask

    task automatic drain_and_clear();
        rx_rdy = 1'b1;
        wait_clk(1);
        rx_rdy = 1'b0;
        clr_status = 1'b1;
        wait_clk(1);
        clr_status = 1'b0;
        wait_clk(2);
    endtask

    task automatic spi_word(input logic [7:0] mo, input bit last, input bit pulse_last,
                            output logic [7:0] mi);
        for (int i = 7; i >= 0; i--) begin
            mosi = mo[i];
            wait_clk(4);
            mi[i] = miso;
            sclk = 1'b1;
            if (i == 0 && pulse_last) begin
                // rx_rdy high exactly on the clk that processes the synced rise
                wait_clk(2);
                rx_rdy = 1'b1;
                wait_clk(1);
                rx_rdy = 1'b0;
                wait_clk(1);
            end else begin
                wait_clk(4);
            end
            sclk = 1'b0;
            if (i == 0 && last) cs = 1'b1;
        end
    endtask

    task automatic frame(input int nw, input logic [7:0] mo0, input logic [7:0] mo1,
                         input bit pulse2, output logic [7:0] mi0, output logic [7:0] mi1);
        cs = 1'b0;
        spi_word(mo0, nw == 1, 1'b0, mi0);
        mi1 = 8'h00;
        if (nw == 2) spi_word(mo1, 1'b1, pulse2, mi1);
        wait_clk(8);
    endtask

    typedef struct {
        logic       preload;
        logic [7:0] tx_w;
        int         nw;
        logic [7:0] mo0, mo1;
        logic [7:0] exp_mi0, exp_mi1, exp_rx;
        logic       exp_val, exp_ovf, exp_udf;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [7:0] mi0, mi1;

        vecs[0] = '{1'b1, 8'hA5, 1, 8'h3C, 8'h00, 8'hA5, 8'h00, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 2, 8'h55, 8'hAA, 8'h00, 8'h00, 8'h55, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 8'h81, 1, 8'hFF, 8'h00, 8'h81, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 8'h7E, 2, 8'h01, 8'h80, 8'h7E, 8'h00, 8'h01, 1'b1, 1'b1, 1'b1};

        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        rx_rdy = 1'b0; tx_msg = 8'h00; tx_val = 1'b0; clr_status = 1'b0;
        wait_clk(3);
        check("rst_miso", miso, 0);
        check("rst_miso_en", miso_en, 0);
        check("rst_rx_msg", rx_msg, 0);
        check("rst_rx_val", rx_val, 0);
        check("rst_tx_rdy", tx_rdy, 1);
        check("rst_overflow", overflow, 0);
        check("rst_underflow", underflow, 0);
        reset = 1'b0;
        wait_clk(4);

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].preload) tx_write(vecs[v].tx_w);
            frame(vecs[v].nw, vecs[v].mo0, vecs[v].mo1, 1'b0, mi0, mi1);
            check($sformatf("v%0d_miso0", v), mi0, vecs[v].exp_mi0);
            if (vecs[v].nw == 2) check($sformatf("v%0d_miso1", v), mi1, vecs[v].exp_mi1);
            check($sformatf("v%0d_rx_msg", v), rx_msg, vecs[v].exp_rx);
            check($sformatf("v%0d_rx_val", v), rx_val, vecs[v].exp_val);
            check($sformatf("v%0d_overflow", v), overflow, vecs[v].exp_ovf);
            check($sformatf("v%0d_underflow", v), underflow, vecs[v].exp_udf);
            check($sformatf("v%0d_tx_rdy", v), tx_rdy, 1);
            check($sformatf("v%0d_miso_en_idle", v), miso_en, 0);
            drain_and_clear();
            if (vecs[v].exp_ovf || vecs[v].exp_udf) begin
                check($sformatf("v%0d_clr_overflow", v), overflow, 0);
                check($sformatf("v%0d_clr_underflow", v), underflow, 0);
            end
        end

        // Back-to-back words, second tx word written while the first is shifting.
        rx_q.delete();
        rx_rdy = 1'b1;
        tx_write(8'h11);
        fork
            frame(2, 8'hF0, 8'h0F, 1'b0, mi0, mi1);
            begin
                wait_clk(20);
                tx_write(8'h22);
            end
        join
        rx_rdy = 1'b0;
        check("b2b_miso0", mi0, 8'h11);
        check("b2b_miso1", mi1, 8'h22);
        check("b2b_rx_count", rx_q.size(), 2);
        if (rx_q.size() == 2) begin
            check("b2b_rx0", rx_q[0], 8'hF0);
            check("b2b_rx1", rx_q[1], 8'h0F);
        end
        check("b2b_underflow", underflow, 0);
        check("b2b_overflow", overflow, 0);
        drain_and_clear();

        // Abort after 5 sclk rises, then a clean frame from bit 0.
        tx_write(8'h99);
        cs = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mosi = i[0];
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
        cs = 1'b1;
        wait_clk(8);
        check("abort_rx_val", rx_val, 0);
        check("abort_miso_en", miso_en, 0);
        tx_write(8'h5A);
        frame(1, 8'hC3, 8'h00, 1'b0, mi0, mi1);
        check("post_abort_miso", mi0, 8'h5A);
        check("post_abort_rx_msg", rx_msg, 8'hC3);
        check("post_abort_rx_val", rx_val, 1);

        // Reset mid-frame with rx word pending and tx holding register full.
        tx_write(8'h33);
        cs = 1'b0;
        wait_clk(4);
        tx_write(8'h44);
        for (int i = 0; i < 3; i++) begin
            mosi = 1'b1;
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(2);
        check("pre_rst_tx_rdy", tx_rdy, 0);
        check("pre_rst_rx_val", rx_val, 1);
        check("pre_rst_miso_en", miso_en, 1);
        reset = 1'b1;
        cs = 1'b1;
        #1;
        check("midrst_miso", miso, 0);
        check("midrst_miso_en", miso_en, 0);
        check("midrst_rx_msg", rx_msg, 0);
        check("midrst_rx_val", rx_val, 0);
        check("midrst_tx_rdy", tx_rdy, 1);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(4);
        for (int i = 0; i < 2; i++) begin
            wait_clk(4);
            sclk = 1'b1;
            wait_clk(4);
            sclk = 1'b0;
        end
        wait_clk(4);
        check("idle_sclk_miso_en", miso_en, 0);
        check("idle_sclk_rx_val", rx_val, 0);
        tx_write(8'h6C);
        frame(1, 8'h93, 8'h00, 1'b0, mi0, mi1);
        check("post_rst_miso", mi0, 8'h6C);
        check("post_rst_rx_msg", rx_msg, 8'h93);
        check("post_rst_rx_val", rx_val, 1);
        check("post_rst_underflow", underflow, 0);
        drain_and_clear();

        // rx_rdy pulse on the exact cycle the second word completes.
        tx_write(8'h12);
        frame(2, 8'hDE, 8'hAD, 1'b1, mi0, mi1);
        check("same_cyc_miso0", mi0, 8'h12);
        check("same_cyc_rx_val", rx_val, 1);
        check("same_cyc_rx_msg", rx_msg, 8'hAD);
        check("same_cyc_overflow", overflow, 0);
        drain_and_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
